// File: rtl/hazard_ctrl.sv
// Hazard controller for a five-stage RV32IMA core: decides front-end stalls,
// ID/EX bubbles and IF/ID squashes, and counts stall and flush cycles.
module hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode_id,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  input  logic [4:0]           rd_ex,
  input  logic                 mem_read_ex,
  input  logic                 reg_write_ex,
  input  logic                 branch_taken_id,
  output logic                 stall,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_flush,
  output logic                 if_id_flush,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  typedef enum logic {RUN, HOLD2} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic uses_rs1, uses_rs2, id_resolves, match;
  logic load_use, alu_br, load_br;

  assign uses_rs1    = !(opcode_id inside {OP_LUI, OP_AUIPC, OP_JAL, OP_NOP});
  assign uses_rs2    = opcode_id inside {OP_RTYPE, OP_STORE, OP_BRANCH, OP_AMO};
  assign id_resolves = opcode_id inside {OP_BRANCH, OP_JALR};

  // x0 is deliberately not exempt: rd_ex==0 matches like any other register.
  assign match = (uses_rs1 && (rs1_id == rd_ex)) || (uses_rs2 && (rs2_id == rd_ex));

  assign load_use = mem_read_ex && match && !id_resolves;
  assign alu_br   = reg_write_ex && !mem_read_ex && match && id_resolves;
  assign load_br  = mem_read_ex && match && id_resolves;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     state_d = load_br ? HOLD2 : RUN;
      HOLD2:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stall wins over a taken branch: operands are not valid during a stall, so
  // the branch re-resolves once the stall releases.
  always_comb begin
    stall       = 1'b0;
    if_id_flush = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN:     stall = load_use || alu_br || load_br;
        HOLD2:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
      if_id_flush = branch_taken_id && !stall;
    end
    pc_en       = !stall;
    if_id_en    = !stall;
    id_ex_flush = stall;
  end

  assign stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, stall};
  assign flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, if_id_flush};

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a stall-length model checked every cycle,
// plus literal expectations; a narrow-counter instance exercises wrap-around.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode_id = '0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       mem_read_ex = 1'b0, reg_write_ex = 1'b0, branch_taken_id = 1'b0;

  logic        stall, pc_en, if_id_en, id_ex_flush, if_id_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_stall, s_pc_en, s_if_id_en, s_id_ex_flush, s_if_id_flush;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex),
    .branch_taken_id(branch_taken_id), .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_WIDTH(3)) dut_w (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex),
    .branch_taken_id(branch_taken_id), .stall(s_stall), .pc_en(s_pc_en),
    .if_id_en(s_if_id_en), .id_ex_flush(s_id_ex_flush), .if_id_flush(s_if_id_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: how many stall cycles the instruction pair in ID/EX demands.
  function automatic int need_stall(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                    input logic [4:0] rd, input logic mr, input logic rw);
    bit reads_r1, reads_r2, early, dep;
    reads_r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f || op == 7'h00);
    reads_r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63 || op == 7'h2f);
    early    = (op == 7'h63 || op == 7'h67);
    dep      = (reads_r1 && r1 == rd) || (reads_r2 && r2 == rd);
    if (mr && dep) return early ? 2 : 1;
    if (rw && dep && early) return 1;
    return 0;
  endfunction

  int          m_hold = 0;   // forced stall cycles still owed after this one
  int unsigned m_sc = 0, m_fc = 0;

  function automatic bit m_stall();
    if (reset) return 1'b0;
    return (m_hold > 0) ||
           (need_stall(opcode_id, rs1_id, rs2_id, rd_ex, mem_read_ex, reg_write_ex) > 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hold <= 0;
      m_sc   <= 0;
      m_fc   <= 0;
    end else begin
      m_sc <= m_sc + (m_stall() ? 1 : 0);
      m_fc <= m_fc + ((branch_taken_id && !m_stall()) ? 1 : 0);
      if (m_hold > 0) m_hold <= m_hold - 1;
      else if (need_stall(opcode_id, rs1_id, rs2_id, rd_ex, mem_read_ex, reg_write_ex) == 2)
        m_hold <= 1;
    end
  end

  always @(negedge clk) begin
    bit st, fl;
    st = m_stall();
    fl = !reset && branch_taken_id && !st;
    chk("stall", stall, st);
    chk("pc_en", pc_en, !st);
    chk("if_id_en", if_id_en, !st);
    chk("id_ex_flush", id_ex_flush, st);
    chk("if_id_flush", if_id_flush, fl);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    chk("w_stall", s_stall, st);
    chk("w_stall_cnt", s_stall_cnt, m_sc % 8);
    chk("w_flush_cnt", s_flush_cnt, m_fc % 8);
  end

  task automatic vec(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic mr, input logic rw, input logic bt);
    @(posedge clk);
    #1;
    opcode_id = op; rs1_id = r1; rs2_id = r2; rd_ex = rd;
    mem_read_ex = mr; reg_write_ex = rw; branch_taken_id = bt;
    @(negedge clk);
  endtask

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
                           7'h6f, 7'h37, 7'h17, 7'h2f, 7'h00, 7'h73};

  initial begin
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_cnt", stall_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;

    // ADD x5, x3, x7 after a load to x7
    vec(7'h33, 3, 7, 7, 1, 1, 0);
    chk("add_ld_stall", stall, 1); chk("add_ld_pc_en", pc_en, 0); chk("add_ld_bubble", id_ex_flush, 1);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("add_ld_release", stall, 0); chk("add_ld_cnt", stall_cnt, 1);

    // ADDI ignores rs2, then depends via rs1
    vec(7'h13, 4, 9, 9, 1, 1, 0);
    chk("addi_rs2_nostall", stall, 0);
    vec(7'h13, 9, 9, 9, 1, 1, 0);
    chk("addi_rs1_stall", stall, 1);

    // BEQ consuming a load: two stall cycles, second ignores inputs
    vec(7'h63, 6, 1, 6, 1, 1, 0);
    chk("beq_ld_c1", stall, 1);
    vec(7'h33, 17, 22, 30, 0, 1, 1);
    chk("beq_ld_c2", stall, 1); chk("beq_ld_noflush", if_id_flush, 0);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("beq_ld_c3", stall, 0); chk("beq_ld_cnt", stall_cnt, 4);

    // BEQ consuming an ALU result: one cycle
    vec(7'h63, 6, 1, 6, 0, 1, 0);
    chk("beq_alu_c1", stall, 1);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("beq_alu_c2", stall, 0); chk("beq_alu_cnt", stall_cnt, 5);

    // Opcodes that read no registers never stall
    vec(7'h6f, 5, 5, 5, 1, 1, 0); chk("jal_nostall", stall, 0);
    vec(7'h37, 5, 5, 5, 1, 1, 0); chk("lui_nostall", stall, 0);
    vec(7'h17, 5, 5, 5, 1, 1, 0); chk("auipc_nostall", stall, 0);
    vec(7'h00, 5, 5, 5, 1, 1, 0); chk("nop_nostall", stall, 0);

    // x0 is not exempt
    vec(7'h33, 0, 8, 0, 1, 1, 0); chk("x0_match", stall, 1);

    // Taken branch with no hazard squashes IF/ID
    vec(7'h00, 0, 0, 0, 0, 0, 1);
    chk("taken_flush", if_id_flush, 1);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("taken_cnt", flush_cnt, 1);

    // Reset asserted in the middle of HOLD2
    vec(7'h63, 6, 1, 6, 1, 1, 0);
    vec(7'h00, 0, 0, 0, 0, 0, 1);
    chk("hold2_stall", stall, 1); chk("hold2_noflush", if_id_flush, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_hold2_stall", stall, 0); chk("rst_hold2_pc_en", pc_en, 1);
    chk("rst_hold2_flush", if_id_flush, 0);
    chk("rst_hold2_scnt", stall_cnt, 0); chk("rst_hold2_fcnt", flush_cnt, 0);
    @(posedge clk); @(posedge clk);
    #1;
    branch_taken_id = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_nostall", stall, 0);

    // Back-to-back load-use stalls wrap the narrow counter
    for (int i = 0; i < 12; i++) vec(7'h33, 5'(i + 1), 0, 5'(i + 1), 1, 1, 0);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("burst_scnt", stall_cnt, 12); chk("burst_wrap", s_stall_cnt, 4);
    for (int i = 0; i < 9; i++) vec(7'h00, 0, 0, 0, 0, 0, 1);
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    chk("flush_fcnt", flush_cnt, 9); chk("flush_wrap", s_flush_cnt, 1);

    // Mixed sweep over the opcode table with a narrow register range
    for (int i = 0; i < 80; i++) begin
      logic mr;
      mr = 1'($urandom_range(0, 1));
      vec(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), mr, mr | 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    vec(7'h00, 0, 0, 0, 0, 0, 0);
    vec(7'h00, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32IMA five-stage core. It watches the instruction in ID and the producer in EX, and generates PC/IF-ID hold, ID-EX bubble and IF-ID flush controls. A two-state FSM sequences the 2-cycle stall needed when a branch or JALR in ID consumes a load result. Free-running event counters expose stall and flush cycles for performance monitoring.

## Interface
- CNT_WIDTH, 32, width of the stall and flush event counters
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears FSM and counters
- opcode_id  in  7  opcode of instruction in ID (0 = NOP/bubble)
- rs1_id  in  5  rs1 field of instruction in ID
- rs2_id  in  5  rs2 field of instruction in ID
- rd_ex  in  5  destination register of instruction in EX
- mem_read_ex  in  1  instruction in EX is a load
- reg_write_ex  in  1  instruction in EX writes rd
- branch_taken_id  in  1  branch/JAL/JALR in ID resolved as taken this cycle
- stall  out  1  pipeline front end held this cycle
- pc_en  out  1  PC register enable (= !stall)
- if_id_en  out  1  IF/ID register enable (= !stall)
- id_ex_flush  out  1  load bubble into ID/EX (= stall)
- if_id_flush  out  1  squash instruction in IF/ID
- stall_cnt  out  CNT_WIDTH  number of cycles with stall=1
- flush_cnt  out  CNT_WIDTH  number of cycles with if_id_flush=1

## Operation
- Operand usage decoded from opcode_id:
  - uses_rs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111, 0000000.
  - uses_rs2: only R-type 0110011, STORE 0100011, BRANCH 1100011, AMO 0101111.
  - id_resolves: BRANCH 1100011 or JALR 1100111 (operands needed in ID).
- match = (uses_rs1 && rs1_id==rd_ex) || (uses_rs2 && rs2_id==rd_ex). x0 is not exempt: rd_ex==0 matches like any register.
- Hazard classes evaluated in state RUN:
  - LOAD_USE: mem_read_ex && match && !id_resolves -> stall 1 cycle.
  - ALU_BR: reg_write_ex && !mem_read_ex && match && id_resolves -> stall 1 cycle.
  - LOAD_BR: mem_read_ex && match && id_resolves -> stall 2 cycles.
  - none -> stall=0.
- FSM states RUN, HOLD2.
  - RUN: stall as above; LOAD_BR -> HOLD2 next cycle; otherwise stay RUN.
  - HOLD2: stall=1 unconditionally, inputs ignored; always -> RUN.
- After HOLD2 the cycle returning to RUN evaluates hazards normally; EX holds a bubble (mem_read_ex=reg_write_ex=0) so no stall arises; stall is never high 3 consecutive cycles.
- JAL (1101111) and NOP (0) in ID never cause stall.
- if_id_flush = branch_taken_id && !stall. Stall wins: a taken indication during a stall cycle is ignored (operands not yet valid); the branch re-resolves when the stall releases.
- Counters: stall_cnt += 1 on each cycle stall=1; flush_cnt += 1 on each cycle if_id_flush=1; both wrap modulo 2^CNT_WIDTH.

## Timing
- stall, pc_en, if_id_en, id_ex_flush, if_id_flush: combinational from inputs and current state, same cycle.
- FSM state and counters update on rising clk; counters reflect an event one cycle after it.
- Reset (async assert, any time, including in HOLD2): state=RUN, stall_cnt=0, flush_cnt=0; while reset=1 outputs forced stall=0, pc_en=1, if_id_en=1, id_ex_flush=0, if_id_flush=0.
- First edge after reset deassert evaluates from RUN.
- Stall lengths: LOAD_USE 1, ALU_BR 1, LOAD_BR exactly 2, others 0.

## Test plan
- ADD x5 in ID (0110011, rs1=3, rs2=7), load rd_ex=7 in EX -> stall=1, pc_en=0, id_ex_flush=1 for 1 cycle; stall_cnt 0->1.
- ADDI (0010011, rs1=4, rs2 field=9), load rd_ex=9 -> stall=0 (rs2 unused); same with rs1=9 -> 1-cycle stall.
- BEQ (1100011, rs1=6) with load rd_ex=6 -> stall 2 cycles, HOLD2 in second cycle with inputs randomized, stall=0 third cycle; stall_cnt +2. Same with ALU rd_ex=6, mem_read_ex=0 -> 1 cycle.
- JAL/LUI/AUIPC/NOP in ID with load rd_ex equal to rs1_id and rs2_id -> stall=0 always.
- branch_taken_id=1 in RUN with no hazard -> if_id_flush=1, flush_cnt +1; branch_taken_id=1 during HOLD2 -> if_id_flush=0.
- Assert reset during HOLD2 -> outputs immediately at reset values, counters 0, no stall after release; preload counters to 2^32-1 and trigger event -> wraps to 0.
